// File: rtl/dir_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dir_pkg
//  Purpose  : Shared constants and types for the direction decoder: the
//             orientation bin count and width, and the cos/sin table format
//             (signed Q1.7).
//  Revision : 1.0 - initial release
// ============================================================================
package dir_pkg;

  localparam int DIR_BINS = 32;  // orientation bins over a full turn
  localparam int DIR_W    = 5;   // bits to address one bin
  localparam int CS_W     = 8;   // cos/sin table entry width
  localparam int CS_FRAC  = 7;   // fractional bits in a table entry

  typedef logic signed [CS_W-1:0] cs_t;

endpackage
`default_nettype wire

// File: rtl/dir_decode_if.sv
`default_nettype none
// ============================================================================
//  Module   : dir_decode_if
//  Purpose  : Handshake bundle for the direction decoder. It carries the
//             input sample stream (bin + magnitude), the output vector stream
//             (dx, dy) and the transfer counter.
//  Modports : slave  - the decoder side (consumes s_*, produces m_*)
//             master - the driver/consumer side (the mirror image)
//  Revision : 1.0 - initial release
// ============================================================================
interface dir_decode_if #(
  parameter int MAG_W = 8
) ();
  import dir_pkg::*;

  logic                    s_valid;
  logic                    s_ready;
  logic [DIR_W-1:0]        s_dir;
  logic [MAG_W-1:0]        s_mag;
  logic                    m_valid;
  logic                    m_ready;
  logic signed [MAG_W:0]   m_dx;
  logic signed [MAG_W:0]   m_dy;
  logic [15:0]             xfer_cnt;

  modport slave (
    input  s_valid, s_dir, s_mag, m_ready,
    output s_ready, m_valid, m_dx, m_dy, xfer_cnt
  );

  modport master (
    output s_valid, s_dir, s_mag, m_ready,
    input  s_ready, m_valid, m_dx, m_dy, xfer_cnt
  );

endinterface
`default_nettype wire

// File: rtl/dir_cs_rom.sv
`default_nettype none
// ============================================================================
//  Module   : dir_cs_rom
//  Purpose  : Combinational cos/sin lookup for a 5-bit orientation bin.
//             Entries are round(127*cos(k*pi/16)) and round(127*sin(k*pi/16)).
//  Ports    : a     - bin index 0..31
//             cos_o - signed Q1.7 cosine
//             sin_o - signed Q1.7 sine
//  Revision : 1.0 - initial release
// ============================================================================
module dir_cs_rom
  import dir_pkg::*;
(
  input  logic [DIR_W-1:0] a,
  output cs_t              cos_o,
  output cs_t              sin_o
);

  always_comb begin
    cos_o = '0;
    sin_o = '0;
    case (a)
      5'd0 : begin cos_o =  8'sd127; sin_o =  8'sd0;   end
      5'd1 : begin cos_o =  8'sd125; sin_o =  8'sd25;  end
      5'd2 : begin cos_o =  8'sd117; sin_o =  8'sd49;  end
      5'd3 : begin cos_o =  8'sd106; sin_o =  8'sd71;  end
      5'd4 : begin cos_o =  8'sd90;  sin_o =  8'sd90;  end
      5'd5 : begin cos_o =  8'sd71;  sin_o =  8'sd106; end
      5'd6 : begin cos_o =  8'sd49;  sin_o =  8'sd117; end
      5'd7 : begin cos_o =  8'sd25;  sin_o =  8'sd125; end
      5'd8 : begin cos_o =  8'sd0;   sin_o =  8'sd127; end
      5'd9 : begin cos_o = -8'sd25;  sin_o =  8'sd125; end
      5'd10: begin cos_o = -8'sd49;  sin_o =  8'sd117; end
      5'd11: begin cos_o = -8'sd71;  sin_o =  8'sd106; end
      5'd12: begin cos_o = -8'sd90;  sin_o =  8'sd90;  end
      5'd13: begin cos_o = -8'sd106; sin_o =  8'sd71;  end
      5'd14: begin cos_o = -8'sd117; sin_o =  8'sd49;  end
      5'd15: begin cos_o = -8'sd125; sin_o =  8'sd25;  end
      5'd16: begin cos_o = -8'sd127; sin_o =  8'sd0;   end
      5'd17: begin cos_o = -8'sd125; sin_o = -8'sd25;  end
      5'd18: begin cos_o = -8'sd117; sin_o = -8'sd49;  end
      5'd19: begin cos_o = -8'sd106; sin_o = -8'sd71;  end
      5'd20: begin cos_o = -8'sd90;  sin_o = -8'sd90;  end
      5'd21: begin cos_o = -8'sd71;  sin_o = -8'sd106; end
      5'd22: begin cos_o = -8'sd49;  sin_o = -8'sd117; end
      5'd23: begin cos_o = -8'sd25;  sin_o = -8'sd125; end
      5'd24: begin cos_o =  8'sd0;   sin_o = -8'sd127; end
      5'd25: begin cos_o =  8'sd25;  sin_o = -8'sd125; end
      5'd26: begin cos_o =  8'sd49;  sin_o = -8'sd117; end
      5'd27: begin cos_o =  8'sd71;  sin_o = -8'sd106; end
      5'd28: begin cos_o =  8'sd90;  sin_o = -8'sd90;  end
      5'd29: begin cos_o =  8'sd106; sin_o = -8'sd71;  end
      5'd30: begin cos_o =  8'sd117; sin_o = -8'sd49;  end
      5'd31: begin cos_o =  8'sd125; sin_o = -8'sd25;  end
      default: begin cos_o = '0; sin_o = '0; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dir_decode.sv
`default_nettype none
// ============================================================================
//  Module   : dir_decode
//  Purpose  : Converts a quantized orientation bin plus unsigned magnitude
//             into a signed (dx, dy) vector through a 2-stage pipeline:
//               stage 1 - registers cos/sin of the bin and the magnitude
//               stage 2 - registers floor((mag*cos)/128), floor((mag*sin)/128)
//             A single advance enable (output empty or being taken) moves the
//             whole pipeline, so backpressure stalls every stage together.
//  Ports    : clk   - rising-edge clock
//             rst_n - synchronous active-low reset
//             bus   - dir_decode_if.slave: s_valid/s_ready/s_dir/s_mag in,
//                     m_valid/m_ready/m_dx/m_dy out, xfer_cnt
//  Config   : DIR_DECODE_CNT_EN - when defined, xfer_cnt counts output
//             transfers and saturates at 16'hFFFF; otherwise it reads 0.
//  Revision : 1.0 - initial release
// ============================================================================
module dir_decode
  import dir_pkg::*;
#(
  parameter int MAG_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  dir_decode_if.slave  bus
);

  // Product width: unsigned magnitude (zero-extended) times signed Q1.7.
  localparam int PW = MAG_W + CS_W + 1;

  logic                  w_en;
  cs_t                   w_cos;
  cs_t                   w_sin;

  logic                  r_v1;
  cs_t                   r_cos1;
  cs_t                   r_sin1;
  logic [MAG_W-1:0]      r_mag1;

  logic                  r_v2;
  logic signed [MAG_W:0] r_dx;
  logic signed [MAG_W:0] r_dy;

  logic signed [PW-1:0]  w_mag_ext;
  logic signed [PW-1:0]  w_cos_ext;
  logic signed [PW-1:0]  w_sin_ext;
  logic signed [PW-1:0]  w_px;
  logic signed [PW-1:0]  w_py;
  logic                  w_unused_bits;

  // The pipeline may advance whenever the output register is free or is
  // being drained this cycle.
  assign w_en        = !r_v2 | bus.m_ready;
  assign bus.s_ready = w_en;

  dir_cs_rom u_rom (
    .a     (bus.s_dir),
    .cos_o (w_cos),
    .sin_o (w_sin)
  );

  // Stage 1 payload carries no reset: it is only consumed when r_v1 is set.
  always_ff @(posedge clk) begin
    if (w_en && bus.s_valid) begin
      r_cos1 <= w_cos;
      r_sin1 <= w_sin;
      r_mag1 <= bus.s_mag;
    end
  end

  assign w_mag_ext = signed'({{(CS_W+1){1'b0}}, r_mag1});
  assign w_cos_ext = {{(MAG_W+1){r_cos1[CS_W-1]}}, r_cos1};
  assign w_sin_ext = {{(MAG_W+1){r_sin1[CS_W-1]}}, r_sin1};
  assign w_px      = w_mag_ext * w_cos_ext;
  assign w_py      = w_mag_ext * w_sin_ext;

  // Taking bits [MAG_W+CS_FRAC:CS_FRAC] is an arithmetic shift right by
  // CS_FRAC (floor rounding); |mag*cos| < 2^(MAG_W+CS_FRAC) so the dropped
  // top bit is only a sign copy.
  assign w_unused_bits = ^{w_px[PW-1:MAG_W+CS_FRAC+1], w_px[CS_FRAC-1:0],
                           w_py[PW-1:MAG_W+CS_FRAC+1], w_py[CS_FRAC-1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_dx <= '0;
      r_dy <= '0;
    end else if (w_en) begin
      // Valid bits follow the data, so an empty slot moves down as a bubble.
      r_v1 <= bus.s_valid;
      r_v2 <= r_v1;
      if (r_v1) begin
        r_dx <= w_px[MAG_W+CS_FRAC:CS_FRAC];
        r_dy <= w_py[MAG_W+CS_FRAC:CS_FRAC];
      end
    end
  end

  assign bus.m_valid = r_v2;
  assign bus.m_dx    = r_dx;
  assign bus.m_dy    = r_dy;

`ifdef DIR_DECODE_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_v2 && bus.m_ready && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.xfer_cnt = r_cnt;
`else
  assign bus.xfer_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dir_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dir_decode
//  Purpose  : Directed self-checking bench for dir_decode: reset state,
//             single-sample latency, table corners, a 32-sample burst against
//             a real-valued reference, backpressure, mid-flight reset and the
//             transfer counter (DIR_DECODE_CNT_EN aware).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dir_decode;

  localparam int MAG_W = 8;
  localparam real PI   = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_cnt;

  dir_decode_if #(.MAG_W(MAG_W)) bus ();

  dir_decode #(.MAG_W(MAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int ref_cs(input int k, input bit is_sin);
    real ang;
    real v;
    ang = real'(k) * PI / 16.0;
    v   = is_sin ? $sin(ang) : $cos(ang);
    return $rtoi($floor(127.0 * v + 0.5));
  endfunction

  function automatic int ref_scale(input int mag, input int cs);
    return $rtoi($floor(real'(mag) * real'(cs) / 128.0));
  endfunction

  // One isolated sample: result must show up exactly 2 edges later for one cycle.
  task automatic send_one(input int dir, input int mag, input int edx, input int edy);
    bus.s_valid = 1'b1;
    bus.s_dir   = 5'(dir);
    bus.s_mag   = 8'(mag);
    tick();
    bus.s_valid = 1'b0;
    chk("lat1_mvalid", int'(bus.m_valid), 0);
    tick();
    chk("out_mvalid", int'(bus.m_valid), 1);
    chk("out_dx", int'(bus.m_dx), edx);
    chk("out_dy", int'(bus.m_dy), edy);
    tick();
    chk("pulse_end", int'(bus.m_valid), 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_dir   = '0;
    bus.s_mag   = '0;
    bus.m_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_mvalid", int'(bus.m_valid), 0);
    chk("rst_dx", int'(bus.m_dx), 0);
    chk("rst_dy", int'(bus.m_dy), 0);
    chk("rst_cnt", int'(bus.xfer_cnt), 0);
    bus.m_ready = 1'b0;
    #1;
    chk("rst_sready", int'(bus.s_ready), 1);
    bus.m_ready = 1'b1;
    rst_n = 1'b1;
    tick();

    // Directed corners
    send_one(0, 200, 198, 0);
    send_one(8, 100, 0, 99);
    send_one(16, 100, -100, 0);
    send_one(4, 128, 90, 90);

    // 32 back-to-back samples, no bubbles
    for (int cyc = 0; cyc <= 32; cyc++) begin
      if (cyc < 32) begin
        bus.s_valid = 1'b1;
        bus.s_dir   = 5'(cyc);
        bus.s_mag   = 8'd255;
      end else begin
        bus.s_valid = 1'b0;
      end
      tick();
      if (cyc >= 1) begin
        chk("b2b_mvalid", int'(bus.m_valid), 1);
        chk("b2b_dx", int'(bus.m_dx), ref_scale(255, ref_cs(cyc - 1, 1'b0)));
        chk("b2b_dy", int'(bus.m_dy), ref_scale(255, ref_cs(cyc - 1, 1'b1)));
      end
    end
    tick();
    chk("b2b_drain", int'(bus.m_valid), 0);

    // Backpressure: 5 edges with m_ready low, 3 samples offered
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1; bus.s_dir = 5'd0;  bus.s_mag = 8'd100;   // A
    #1;
    chk("bp_sready_a", int'(bus.s_ready), 1);
    tick();
    bus.s_dir = 5'd8;  bus.s_mag = 8'd50;                        // B
    chk("bp_sready_b", int'(bus.s_ready), 1);
    tick();
    bus.s_dir = 5'd24; bus.s_mag = 8'd64;                        // C
    chk("bp_sready_c", int'(bus.s_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_mvalid", int'(bus.m_valid), 1);
      chk("bp_hold_dx", int'(bus.m_dx), 99);
      chk("bp_hold_dy", int'(bus.m_dy), 0);
      chk("bp_hold_sready", int'(bus.s_ready), 0);
    end
    bus.m_ready = 1'b1;
    #1;
    chk("bp_release_sready", int'(bus.s_ready), 1);
    tick();
    bus.s_valid = 1'b0;
    chk("bp_b_mvalid", int'(bus.m_valid), 1);
    chk("bp_b_dx", int'(bus.m_dx), 0);
    chk("bp_b_dy", int'(bus.m_dy), 49);
    tick();
    chk("bp_c_mvalid", int'(bus.m_valid), 1);
    chk("bp_c_dx", int'(bus.m_dx), 0);
    chk("bp_c_dy", int'(bus.m_dy), -64);
    tick();
    chk("bp_drain", int'(bus.m_valid), 0);

`ifdef DIR_DECODE_CNT_EN
    exp_cnt = 39;
`else
    exp_cnt = 0;
`endif
    chk("cnt_after_traffic", int'(bus.xfer_cnt), exp_cnt);

    // Reset with two samples in flight (held by m_ready low)
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1; bus.s_dir = 5'd0; bus.s_mag = 8'd10;
    tick();
    bus.s_dir = 5'd4; bus.s_mag = 8'd20;
    tick();
    bus.s_valid = 1'b0;
    chk("inflight_mvalid", int'(bus.m_valid), 1);
    chk("inflight_dx", int'(bus.m_dx), 9);
    rst_n = 1'b0;
    tick();
    chk("midrst_mvalid", int'(bus.m_valid), 0);
    chk("midrst_cnt", int'(bus.xfer_cnt), 0);
    chk("midrst_sready", int'(bus.s_ready), 1);
    bus.m_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_mvalid", int'(bus.m_valid), 0);
    end
    chk("post_rst_cnt", int'(bus.xfer_cnt), 0);

`ifdef DIR_DECODE_CNT_EN
    // Counter saturation
    bus.s_valid = 1'b1; bus.s_dir = 5'd0; bus.s_mag = 8'd1;
    repeat (70000) tick();
    bus.s_valid = 1'b0;
    chk("cnt_sat", int'(bus.xfer_cnt), 65535);
    tick();
    chk("cnt_sat_hold", int'(bus.xfer_cnt), 65535);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dir_decode.md
DIR_DECODE -- requirements
Module: dir_decode

Interface
REQ-001 SHALL have parameter MAG_W, default 8, meaning unsigned gradient magnitude width.
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port s_valid  input  1  the input sample is valid.
REQ-005 SHALL have port s_ready  output  1  the block can accept an input sample.
REQ-006 SHALL have port s_dir  input  5  the quantized orientation bin, 0..31; bin k is centred on k*11.25 degrees, counter-clockwise from +x.
REQ-007 SHALL have port s_mag  input  MAG_W  the unsigned magnitude.
REQ-008 SHALL have port m_valid  output  1  the output vector is valid.
REQ-009 SHALL have port m_ready  input  1  the downstream block accepts the output.
REQ-010 SHALL have port m_dx  output  MAG_W+1  the signed x component.
REQ-011 SHALL have port m_dy  output  MAG_W+1  the signed y component.
REQ-012 SHALL have port xfer_cnt  output  16  the count of output transfers (see Configuration).

Function
REQ-013 SHALL transfer on the input side when s_valid and s_ready are both high in the same cycle, and on the output side when m_valid and m_ready are both high in the same cycle.
REQ-014 SHALL implement a 2-stage pipeline: stage 1 registers the bin's cos/sin values and s_mag; stage 2 registers the products.
REQ-015 SHALL use a global advance enable en = !m_valid | m_ready, with s_ready = en; every stage holds its contents when en is low.
REQ-016 SHALL present the result for a sample on m_valid exactly 2 cycles after it is accepted, provided m_ready stays high.
REQ-017 SHALL sustain a throughput of one sample per cycle under continuous s_valid and m_ready.
REQ-018 SHALL hold the cos/sin table as signed 8-bit Q1.7 values: round(127*cos(k*pi/16)) and round(127*sin(k*pi/16)); for example k=0 gives (127,0), k=4 gives (90,90), k=8 gives (0,127), k=16 gives (-127,0).
REQ-019 SHALL compute m_dx = (s_mag * cos) >>> 7 and m_dy = (s_mag * sin) >>> 7, using a signed product of MAG_W+9 bits and an arithmetic shift, so results are floor-rounded, with no saturation; the results always fit in MAG_W+1 bits.
REQ-020 SHALL keep m_dx, m_dy and m_valid stable while m_valid is high and m_ready is low.
REQ-021 SHALL clear a stage's valid bit when it advances with no data entering it, so bubbles propagate.
REQ-022 SHALL accept a new input in the same cycle that an output transfer completes, when stage 1 is full (simultaneous accept and emit).
REQ-023 SHALL leave s_dir and s_mag don't-care while s_valid is low.

Reset
REQ-024 SHALL, when rst_n is low at a rising edge, clear both stage valid bits, m_valid, m_dx, m_dy and xfer_cnt to 0.
REQ-025 SHALL, on reset asserted mid-operation, discard all in-flight samples without emitting them.
REQ-026 SHALL hold s_ready high during and after reset, because m_valid is 0.

Configuration
REQ-027 SHALL, with DIR_DECODE_CNT_EN defined, increment xfer_cnt by 1 on each output transfer and saturate it at 16'hFFFF.
REQ-028 SHALL, with DIR_DECODE_CNT_EN undefined, keep the xfer_cnt port and tie it to 0, with no counter logic.

Structure
REQ-029 SHALL place DIR_BINS=32, DIR_W=5, CS_W=8 and CS_FRAC=7 in a shared package, dir_pkg.
REQ-030 SHALL implement the table as a combinational sub-module, dir_cs_rom (a: 5-bit bin in; cos_o and sin_o: signed 8-bit out), with a default case output of 0.

Verification
REQ-031 SHALL cover: dir=0, mag=200, m_ready=1 -> after 2 cycles dx=198, dy=0, m_valid=1 for 1 cycle.
REQ-032 SHALL cover: dir=8, mag=100 -> dx=0, dy=99; dir=16, mag=100 -> dx=-100, dy=0; dir=4, mag=128 -> dx=90, dy=90.
REQ-033 SHALL cover: 32 back-to-back samples dir=0..31, mag=255, m_ready=1 -> 32 consecutive outputs matching a floating-point reference table, with no bubbles.
REQ-034 SHALL cover: m_ready held low for 5 cycles with 3 samples offered -> s_ready drops, outputs hold stable, all 3 outputs arrive in order once m_ready is released, and none is lost or duplicated.
REQ-035 SHALL cover: rst_n pulsed low while 2 samples are in flight -> m_valid=0 next cycle, neither sample is emitted, and xfer_cnt=0.
REQ-036 SHALL cover: with DIR_DECODE_CNT_EN defined, 70000 transfers -> xfer_cnt=16'hFFFF; with it undefined -> xfer_cnt stays 0.
